// File: rtl/cavlc_pkg.sv
// Shared types and constants for the CAVLC coeff_token decode path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, table-class codes, the fixed-length zero code,
// datapath widths and the nC -> table-class mapping helper.
package cavlc_pkg;

  // Datapath widths
  localparam int WIN_W  = 16;  // bitstream window
  localparam int TC_W   = 5;   // TotalCoeff
  localparam int SH_W   = 5;   // shift amount
  localparam int LZ_W   = 5;   // leading-zero count, 0..16
  localparam int CLS_W  = 3;   // table class
  localparam int NC_W   = 5;   // neighbour count

  // Decoder states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_BITS = 3'd1,
    ST_LOOKUP    = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERROR     = 3'd5
  } state_t;

  // Table classes; CLS_FLC is decoded locally, the rest go to the LUT bank
  localparam logic [CLS_W-1:0] CLS_NC0 = 3'd0;  // 0 <= nC < 2
  localparam logic [CLS_W-1:0] CLS_NC2 = 3'd1;  // 2 <= nC < 4
  localparam logic [CLS_W-1:0] CLS_NC4 = 3'd2;  // 4 <= nC < 8
  localparam logic [CLS_W-1:0] CLS_FLC = 3'd3;  // nC >= 8, 6-bit fixed code
  localparam logic [CLS_W-1:0] CLS_CDC = 3'd4;  // chroma DC

  // Fixed-length code meaning TotalCoeff = 0, TrailingOnes = 0
  localparam logic [5:0]      FLC_ZERO_CODE = 6'b000011;
  localparam logic [SH_W-1:0] FLC_LEN       = 5'd6;

  // Chroma DC wins over nC; otherwise pick by nC range.
  function automatic logic [CLS_W-1:0] nc_class(input logic            chroma_dc,
                                                 input logic [NC_W-1:0] nc);
    if (chroma_dc)      return CLS_CDC;
    else if (nc < 5'd2) return CLS_NC0;
    else if (nc < 5'd4) return CLS_NC2;
    else if (nc < 5'd8) return CLS_NC4;
    else                return CLS_FLC;
  endfunction

endpackage

// File: rtl/cavlc_lzc16.sv
// Leading-zero counter for the 16-bit bitstream window.
// Latency: combinational.
// Backpressure: none.
//
// Ports: din (window, MSB first), lz (0..16; 16 means all-zero window).
module cavlc_lzc16
  import cavlc_pkg::*;
(
  input  logic [WIN_W-1:0] din,
  output logic [LZ_W-1:0]  lz
);

  logic found;

  // Scan from the MSB; the first set bit fixes the count.
  always_comb begin
    lz    = LZ_W'(WIN_W);
    found = 1'b0;
    for (int i = WIN_W - 1; i >= 0; i--) begin
      if (!found && din[i]) begin
        lz    = LZ_W'(WIN_W - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/coeff_token_ctrl.sv
// Sequences one coeff_token decode: window capture, LUT lookup or FLC decode, shift.
// Latency: Start -> Done in 4 cycles (VLC) or 3 cycles (FLC) with bits/ack ready.
// Backpressure: stalls in WAIT_BITS on BitsValid and in SHIFT on ShiftAck.
//
// Ports: Clk/nRst; Start, nC, ChromaDC request; BitsIn/BitsValid window;
// ShiftReq/ShiftAmt/ShiftAck to the shifter; LutTable/LutLz/LutBits to and
// LutHit/LutTotalCoeff/LutTrailingOnes/LutNumShift from the LUT bank;
// Busy, Done, Error status; TotalCoeff/TrailingOnes result.
module coeff_token_ctrl
  import cavlc_pkg::*;
(
  input  logic              Clk,
  input  logic              nRst,
  input  logic              Start,
  input  logic [NC_W-1:0]   nC,
  input  logic              ChromaDC,
  input  logic [WIN_W-1:0]  BitsIn,
  input  logic              BitsValid,
  output logic              ShiftReq,
  output logic [SH_W-1:0]   ShiftAmt,
  input  logic              ShiftAck,
  output logic [CLS_W-1:0]  LutTable,
  output logic [3:0]        LutLz,
  output logic [WIN_W-1:0]  LutBits,
  input  logic              LutHit,
  input  logic [TC_W-1:0]   LutTotalCoeff,
  input  logic [1:0]        LutTrailingOnes,
  input  logic [SH_W-1:0]   LutNumShift,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [TC_W-1:0]   TotalCoeff,
  output logic [1:0]        TrailingOnes
);

  state_t            state_q, state_d;
  logic [CLS_W-1:0]  cls_q,   cls_d;
  logic [WIN_W-1:0]  bits_q,  bits_d;
  logic [3:0]        lz_q,    lz_d;
  logic [SH_W-1:0]   amt_q,   amt_d;
  logic [TC_W-1:0]   tc_q,    tc_d;
  logic [1:0]        t1_q,    t1_d;

  logic [LZ_W-1:0]   win_lz;
  logic [5:0]        flc_code;
  logic [TC_W-1:0]   flc_tc;
  logic [1:0]        flc_t1;
  logic              flc_err;
  logic              in_lookup;

  cavlc_lzc16 u_lzc (
    .din (BitsIn),
    .lz  (win_lz)
  );

  // Fixed-length code: 4-bit TotalCoeff-1 followed by 2-bit TrailingOnes,
  // except the reserved zero code.
  assign flc_code = BitsIn[WIN_W-1 -: 6];

  always_comb begin
    if (flc_code == FLC_ZERO_CODE) begin
      flc_tc = '0;
      flc_t1 = '0;
    end else begin
      flc_tc = {1'b0, flc_code[5:2]} + 5'd1;
      flc_t1 = flc_code[1:0];
    end
    flc_err = ({3'b000, flc_t1} > flc_tc);
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    bits_d  = bits_q;
    lz_d    = lz_q;
    amt_d   = amt_q;
    tc_d    = tc_q;
    t1_d    = t1_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          cls_d   = nc_class(ChromaDC, nC);
          state_d = ST_WAIT_BITS;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT_BITS: begin
        if (BitsValid) begin
          bits_d = BitsIn;
          lz_d   = win_lz[3:0];
          if (win_lz == LZ_W'(WIN_W)) begin
            // No code in the window can start with 16 zeros.
            tc_d    = '0;
            t1_d    = '0;
            amt_d   = '0;
            state_d = ST_ERROR;
          end else if (cls_q == CLS_FLC) begin
            if (flc_err) begin
              tc_d    = '0;
              t1_d    = '0;
              amt_d   = '0;
              state_d = ST_ERROR;
            end else begin
              tc_d    = flc_tc;
              t1_d    = flc_t1;
              amt_d   = FLC_LEN;
              state_d = ST_SHIFT;
            end
          end else begin
            state_d = ST_LOOKUP;
          end
        end
      end

      ST_LOOKUP: begin
        // A zero-length hit would stall the bitstream forever; treat as illegal.
        if (LutHit && (LutNumShift != '0)) begin
          tc_d    = LutTotalCoeff;
          t1_d    = LutTrailingOnes;
          amt_d   = LutNumShift;
          state_d = ST_SHIFT;
        end else begin
          tc_d    = '0;
          t1_d    = '0;
          amt_d   = '0;
          state_d = ST_ERROR;
        end
      end

      ST_SHIFT: begin
        if (ShiftAck) state_d = ST_DONE;
      end

      ST_ERROR: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= ST_IDLE;
      cls_q   <= CLS_NC0;
      bits_q  <= '0;
      lz_q    <= '0;
      amt_q   <= '0;
      tc_q    <= '0;
      t1_q    <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      bits_q  <= bits_d;
      lz_q    <= lz_d;
      amt_q   <= amt_d;
      tc_q    <= tc_d;
      t1_q    <= t1_d;
    end
  end

  // Status and shifter handshake decode straight from the state register,
  // so reset drops ShiftReq without waiting for a clock.
  assign Busy     = !((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign Done     = (state_q == ST_DONE);
  assign Error    = (state_q == ST_ERROR);
  assign ShiftReq = (state_q == ST_SHIFT);
  assign ShiftAmt = amt_q;

  assign TotalCoeff   = tc_q;
  assign TrailingOnes = t1_q;

  // LUT address is only presented during the lookup cycle.
  assign in_lookup = (state_q == ST_LOOKUP);
  assign LutTable  = in_lookup ? cls_q  : '0;
  assign LutLz     = in_lookup ? lz_q   : '0;
  assign LutBits   = in_lookup ? bits_q : '0;

endmodule
